ppm_tracker: RTL and testbench

Closed-loop clock-drift estimator that generates the signed `ppm_in` correction word consumed by `resampler_q15`. The block counts source-sample strobes against resampler output strobes over fixed windows and turns the rate difference into a PI-filtered phase-increment correction. It sits beside the resampler and closes the loop that keeps resampler consumption matched to the upstream sample rate.

---
 rtl/resampler_pkg.sv | 29 ++
 rtl/rate_window_counter.sv | 82 ++++++++
 rtl/ppm_tracker.sv | 138 +++++++++++++
 tb/tb_ppm_tracker.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/resampler_pkg.sv
// Shared types and helpers for the resampler and its drift-tracking loop.
package resampler_pkg;

  // Drift tracker control states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    TRACK   = 2'd2
  } ppm_trk_state_t;

  // Q-format constants shared with resampler_q15.
  localparam int               Q15_FRAC_BITS = 15;
  localparam logic signed [15:0] Q15_ONE     = 16'sh7FFF;
  localparam int               PPM_WIDTH     = 32;

  // Clamp a 34-bit signed sum into the signed 32-bit range.
  function automatic logic signed [31:0] sat32(input logic signed [33:0] x);
    logic signed [31:0] r;
    if (x > 34'sh0_7FFF_FFFF) begin
      r = 32'sh7FFF_FFFF;
    end else if (x < 34'sh3_8000_0000) begin
      r = 32'sh8000_0000;
    end else begin
      r = x[31:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/rate_window_counter.sv
// Window timer plus source/consumer strobe counters; latches the rate error
// at the end of each window.
module rate_window_counter #(
  parameter int W = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic                arm,
  input  logic                src_strobe,
  input  logic                cons_strobe,
  output logic                tc,
  output logic signed [W+1:0] err,
  output logic                snap
);
  import resampler_pkg::*;

  logic [W-1:0]        wcnt_q, wcnt_d;
  logic [W:0]          src_cnt_q, src_cnt_d;
  logic [W:0]          cons_cnt_q, cons_cnt_d;
  logic signed [W+1:0] err_q, err_d;
  logic                snap_q, snap_d;

  logic                tc_s;
  logic [W:0]          src_tot_s;
  logic [W:0]          cons_tot_s;
  logic signed [W+1:0] err_s;

  // Terminal-count detection and window error including this cycle's strobes.
  always_comb begin
    tc_s       = run && (wcnt_q == {W{1'b1}});
    src_tot_s  = src_cnt_q + {{W{1'b0}}, src_strobe};
    cons_tot_s = cons_cnt_q + {{W{1'b0}}, cons_strobe};
    err_s      = $signed({1'b0, src_tot_s}) - $signed({1'b0, cons_tot_s});
  end

  // Next-state for counters; snapshot reloads counters and latches the error.
  always_comb begin
    wcnt_d     = wcnt_q;
    src_cnt_d  = src_cnt_q;
    cons_cnt_d = cons_cnt_q;
    err_d      = err_q;
    snap_d     = 1'b0;
    if (!run) begin
      wcnt_d     = {W{1'b0}};
      src_cnt_d  = {(W+1){1'b0}};
      cons_cnt_d = {(W+1){1'b0}};
    end else if (tc_s) begin
      wcnt_d     = {W{1'b0}};
      src_cnt_d  = {(W+1){1'b0}};
      cons_cnt_d = {(W+1){1'b0}};
      err_d      = err_s;
      snap_d     = arm;
    end else begin
      wcnt_d     = wcnt_q + W'(1);
      src_cnt_d  = src_tot_s;
      cons_cnt_d = cons_tot_s;
    end
  end

  // Counter and snapshot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q     <= {W{1'b0}};
      src_cnt_q  <= {(W+1){1'b0}};
      cons_cnt_q <= {(W+1){1'b0}};
      err_q      <= {(W+2){1'b0}};
      snap_q     <= 1'b0;
    end else begin
      wcnt_q     <= wcnt_d;
      src_cnt_q  <= src_cnt_d;
      cons_cnt_q <= cons_cnt_d;
      err_q      <= err_d;
      snap_q     <= snap_d;
    end
  end

  assign tc   = tc_s;
  assign err  = err_q;
  assign snap = snap_q;

endmodule

// File: rtl/ppm_tracker.sv
// Clock-drift estimator: PI-filters per-window strobe rate error into the
// resampler's signed ppm correction word.
module ppm_tracker #(
  parameter int                 WINDOW_LOG2 = 12,
  parameter int                 KP_SHIFT    = 8,
  parameter int                 KI_SHIFT    = 4,
  parameter logic signed [31:0] PPM_INIT    = 32'sd0,
  parameter int                 LOCK_TOL    = 1,
  parameter int                 LOCK_COUNT  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          clr,
  input  logic                          src_strobe,
  input  logic                          cons_strobe,
  output logic signed [31:0]            ppm_out,
  output logic                          ppm_valid,
  output logic signed [WINDOW_LOG2+1:0] err_out,
  output logic                          locked
);
  import resampler_pkg::*;

  localparam int W   = WINDOW_LOG2;
  localparam int LCW = $clog2(LOCK_COUNT + 1);
  localparam logic [LCW-1:0]     LC_MAX = LCW'(LOCK_COUNT);
  localparam logic signed [33:0] TOL_P  = 34'(LOCK_TOL);
  localparam logic signed [33:0] TOL_N  = -TOL_P;

  ppm_trk_state_t      state_q, state_d;
  logic signed [31:0]  integ_q, integ_d;
  logic signed [31:0]  ppm_q, ppm_d;
  logic                valid_q, valid_d;
  logic [LCW-1:0]      lock_cnt_q, lock_cnt_d;
  logic                locked_q, locked_d;

  logic                run_s;
  logic                arm_s;
  logic                tc_s;
  logic                snap_s;
  logic signed [W+1:0] err_s;
  logic signed [33:0]  err_ext_s;
  logic signed [31:0]  integ_new_s;
  logic signed [31:0]  ppm_new_s;
  logic                in_lock_s;

  assign run_s = enable && (state_q != IDLE);
  assign arm_s = (state_q == TRACK);

  rate_window_counter #(.W(W)) u_win (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run_s),
    .arm         (arm_s),
    .src_strobe  (src_strobe),
    .cons_strobe (cons_strobe),
    .tc          (tc_s),
    .err         (err_s),
    .snap        (snap_s)
  );

  // PI arithmetic on the latched window error, all at 34 bits before clamping.
  always_comb begin
    err_ext_s   = {{(34-W-2){err_s[W+1]}}, err_s};
    integ_new_s = sat32({{2{integ_q[31]}}, integ_q} + (err_ext_s <<< KI_SHIFT));
    ppm_new_s   = sat32({{2{PPM_INIT[31]}}, PPM_INIT}
                        + {{2{integ_new_s[31]}}, integ_new_s}
                        + (err_ext_s <<< KP_SHIFT));
    in_lock_s   = (err_ext_s <= TOL_P) && (err_ext_s >= TOL_N);
  end

  // FSM sequencing, loop update on tracked snapshots, lock tally, clear override.
  always_comb begin
    state_d    = state_q;
    integ_d    = integ_q;
    ppm_d      = ppm_q;
    valid_d    = 1'b0;
    lock_cnt_d = lock_cnt_q;
    locked_d   = locked_q;
    if (!enable) begin
      state_d    = IDLE;
      lock_cnt_d = {LCW{1'b0}};
      locked_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE:    state_d = ACQUIRE;
        ACQUIRE: state_d = tc_s ? TRACK : ACQUIRE;
        TRACK:   state_d = TRACK;
        default: state_d = IDLE;
      endcase
      if (snap_s) begin
        integ_d = integ_new_s;
        ppm_d   = ppm_new_s;
        valid_d = 1'b1;
        if (in_lock_s) begin
          lock_cnt_d = (lock_cnt_q == LC_MAX) ? lock_cnt_q : lock_cnt_q + LCW'(1);
        end else begin
          lock_cnt_d = {LCW{1'b0}};
        end
        locked_d = (lock_cnt_d == LC_MAX);
      end else begin
        valid_d = 1'b0;
      end
    end
    if (clr) begin
      integ_d = 32'sd0;
      ppm_d   = PPM_INIT;
      valid_d = 1'b0;
    end else begin
      valid_d = valid_d;
    end
  end

  // Loop state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      integ_q    <= 32'sd0;
      ppm_q      <= PPM_INIT;
      valid_q    <= 1'b0;
      lock_cnt_q <= {LCW{1'b0}};
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      integ_q    <= integ_d;
      ppm_q      <= ppm_d;
      valid_q    <= valid_d;
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
    end
  end

  assign ppm_out   = ppm_q;
  assign ppm_valid = valid_q;
  assign err_out   = err_s;
  assign locked    = locked_q;

endmodule

// File: tb/tb_ppm_tracker.sv
// Bench for ppm_tracker: a window-level reference model checked every cycle,
// plus directed scenarios with hand-computed values.
module tb_ppm_tracker;

  localparam int W    = 4;
  localparam int KP   = 8;
  localparam int WLEN = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic en0, clr0, s0, c0;
  logic en1, clr1, s1, c1;
  logic signed [31:0]  ppm0, ppm1;
  logic                v0, v1, l0, l1;
  logic signed [W+1:0] e0, e1;

  ppm_tracker #(.WINDOW_LOG2(W), .KP_SHIFT(KP), .KI_SHIFT(4), .PPM_INIT(32'sd0),
                .LOCK_TOL(1), .LOCK_COUNT(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(en0), .clr(clr0), .src_strobe(s0),
    .cons_strobe(c0), .ppm_out(ppm0), .ppm_valid(v0), .err_out(e0), .locked(l0));

  ppm_tracker #(.WINDOW_LOG2(W), .KP_SHIFT(KP), .KI_SHIFT(26), .PPM_INIT(32'sd0),
                .LOCK_TOL(1), .LOCK_COUNT(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .enable(en1), .clr(clr1), .src_strobe(s1),
    .cons_strobe(c1), .ppm_out(ppm1), .ppm_valid(v1), .err_out(e1), .locked(l1));

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;
  int sat_n = 0;

  // Reference model state, one slot per DUT instance.
  int     ki[2] = '{4, 26};
  bit     m_act[2], m_pend[2], m_valid[2], m_locked[2];
  int     m_win[2], m_pos[2], m_sc[2], m_cc[2], m_lc[2];
  longint m_err[2], m_perr[2], m_integ[2], m_ppm[2];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint sat(input longint x);
    if (x > 64'sd2147483647) return 64'sd2147483647;
    if (x < -64'sd2147483648) return -64'sd2147483648;
    return x;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_pend[i] = 0; m_valid[i] = 0; m_locked[i] = 0;
      m_win[i] = 0; m_pos[i] = 0; m_sc[i] = 0; m_cc[i] = 0; m_lc[i] = 0;
      m_err[i] = 0; m_perr[i] = 0; m_integ[i] = 0; m_ppm[i] = 0;
    end
  endtask

  // One clock edge of behaviour: apply last window's correction, then count.
  task automatic model_step(input int i, input logic en, input logic clr,
                            input logic s, input logic c);
    m_valid[i] = 0;
    if (m_pend[i] && en) begin
      m_integ[i] = sat(m_integ[i] + m_perr[i] * (64'sd1 <<< ki[i]));
      m_ppm[i]   = sat(m_integ[i] + m_perr[i] * (64'sd1 <<< KP));
      m_valid[i] = 1;
      if (m_perr[i] >= -1 && m_perr[i] <= 1) m_lc[i] = (m_lc[i] < 4) ? m_lc[i] + 1 : 4;
      else m_lc[i] = 0;
      m_locked[i] = (m_lc[i] == 4);
    end
    if (clr) begin
      m_integ[i] = 0; m_ppm[i] = 0; m_valid[i] = 0;
    end
    m_pend[i] = 0;
    if (!en) begin
      m_act[i] = 0; m_pos[i] = 0; m_sc[i] = 0; m_cc[i] = 0; m_win[i] = 0;
      m_lc[i] = 0; m_locked[i] = 0;
    end else if (!m_act[i]) begin
      m_act[i] = 1;
    end else begin
      m_sc[i] += int'(s);
      m_cc[i] += int'(c);
      if (m_pos[i] == WLEN - 1) begin
        m_err[i] = m_sc[i] - m_cc[i];
        if (m_win[i] > 0) begin
          m_pend[i] = 1;
          m_perr[i] = m_err[i];
        end
        m_win[i]++;
        m_sc[i] = 0; m_cc[i] = 0; m_pos[i] = 0;
      end else begin
        m_pos[i]++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0, en0, clr0, s0, c0);
    model_step(1, en1, clr1, s1, c1);
    #1;
  endtask

  task automatic check_reset_values();
    check("rst_ppm0", ppm0, 0);  check("rst_valid0", v0, 0);
    check("rst_err0", e0, 0);    check("rst_lock0", l0, 0);
    check("rst_ppm1", ppm1, 0);  check("rst_valid1", v1, 0);
    check("rst_err1", e1, 0);    check("rst_lock1", l1, 0);
  endtask

  // Per-cycle comparison against the model, plus pinned saturation values.
  initial forever begin
    @(negedge clk or negedge rst_n);
    if (!rst_n) begin
      sat_n = 0;
    end else if (chk_on) begin
      check("cyc_ppm0", ppm0, m_ppm[0]);   check("cyc_valid0", v0, longint'(m_valid[0]));
      check("cyc_err0", e0, m_err[0]);     check("cyc_lock0", l0, longint'(m_locked[0]));
      check("cyc_ppm1", ppm1, m_ppm[1]);   check("cyc_valid1", v1, longint'(m_valid[1]));
      check("cyc_err1", e1, m_err[1]);     check("cyc_lock1", l1, longint'(m_locked[1]));
      if (v1) begin
        sat_n++;
        if (sat_n == 1) check("sat_first_ppm", ppm1, 64'sd1073745920);
        else            check("sat_rail_ppm", ppm1, 64'sd2147483647);
      end
    end
  end

  initial begin
    longint got[$];
    rst_n = 1'b0;
    en0 = 0; clr0 = 0; s0 = 0; c0 = 0;
    en1 = 0; clr1 = 0; s1 = 0; c1 = 0;
    model_reset();
    #23;
    check_reset_values();
    rst_n  = 1'b1;
    chk_on = 1'b1;
    en1 = 1; s1 = 1; c1 = 0;

    // Matched rates: first update in cycle 34, lock on the 4th update.
    en0 = 1; s0 = 1; c0 = 1;
    for (int k = 1; k <= 82; k++) begin
      tick();
      if (k == 34 || k == 50 || k == 66 || k == 82) begin
        check("match_valid", v0, 1);
        check("match_ppm", ppm0, 0);
        check("match_err", e0, 0);
      end else begin
        check("match_novalid", v0, 0);
      end
      if (k == 66) check("match_lock3", l0, 0);
      if (k == 82) check("match_lock4", l0, 1);
    end

    // Source fast: err +8, first update 2176; drop enable mid-window.
    en0 = 0;
    tick(); tick();
    check("idle_unlock", l0, 0);
    en0 = 1; s0 = 1;
    for (int k = 1; k <= 40; k++) begin
      c0 = 1'(k % 2);
      tick();
      if (k == 34) begin
        check("fast_first_valid", v0, 1);
        check("fast_err", e0, 8);
        check("fast_ppm0", ppm0, 2176);
        check("fast_lock", l0, 0);
      end
    end
    en0 = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      check("drop_novalid", v0, 0);
      check("drop_hold", ppm0, 2176);
      check("drop_lock", l0, 0);
    end

    // Re-enable: one discarded window, then 2304, 2432.
    en0 = 1;
    for (int k = 1; k <= 50; k++) begin
      c0 = 1'(k % 2);
      tick();
      if (v0) got.push_back(ppm0);
      if (k == 33) check("reacq_novalid", longint'(got.size()), 0);
    end
    check("fast_count", longint'(got.size()), 2);
    if (got.size() == 2) begin
      check("fast_ppm1", got[0], 2304);
      check("fast_ppm2", got[1], 2432);
    end

    // Clear, then source slow: -2176, -2304, then clr on the update edge.
    en0 = 0; clr0 = 1;
    tick();
    clr0 = 0;
    check("clr_ppm", ppm0, 0);
    tick();
    en0 = 1; c0 = 1;
    for (int k = 1; k <= 66; k++) begin
      s0   = 1'(k % 2);
      clr0 = (k == 66);
      tick();
      if (k == 34) begin check("slow_err", e0, -8); check("slow_ppm0", ppm0, -2176); end
      if (k == 50) check("slow_ppm1", ppm0, -2304);
      if (k == 66) begin check("clr_upd_valid", v0, 0); check("clr_upd_ppm", ppm0, 0); end
    end
    clr0 = 0;

    // Random traffic against the model.
    for (int k = 0; k < 900; k++) begin
      en0  = ($urandom_range(0, 199) != 0);
      clr0 = ($urandom_range(0, 99) == 0);
      s0   = ($urandom_range(0, 3) != 0);
      c0   = ($urandom_range(0, 3) != 0);
      tick();
    end

    // Asynchronous reset in the middle of a window.
    for (int k = 0; k < 7; k++) tick();
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_values();
    #1;
    rst_n = 1'b1;
    en0 = 1; clr0 = 0; s0 = 1; c0 = 0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (k == 34) check("post_rst_sat", ppm1, 64'sd1073745920);
    end

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
